// File: rtl/traffic_disp_pkg.sv
// Shared types and constants for the traffic light controller and its display scanner.
// Segment patterns are {a,b,c,d,e,f,g,dp}, active-low.
package traffic_disp_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    FLASH  = 2'd3
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_GREEN  = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  localparam logic [7:0] SEG_0     = 8'b0000_0011;
  localparam logic [7:0] SEG_1     = 8'b1001_1111;
  localparam logic [7:0] SEG_2     = 8'b0010_0101;
  localparam logic [7:0] SEG_3     = 8'b0000_1101;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b0100_1001;
  localparam logic [7:0] SEG_6     = 8'b0100_0001;
  localparam logic [7:0] SEG_7     = 8'b0001_1111;
  localparam logic [7:0] SEG_8     = 8'b0000_0001;
  localparam logic [7:0] SEG_9     = 8'b0000_1001;
  localparam logic [7:0] SEG_R     = 8'b1111_0101;
  localparam logic [7:0] SEG_G     = 8'b0100_0011;
  localparam logic [7:0] SEG_Y     = 8'b1000_1001;
  localparam logic [7:0] SEG_DASH  = 8'b1111_1101;
  localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner: ones/tens of remaining on digits 0/1, state letter on top digit.
// Honours NIGHT_FLASH_EN for the FLASH state display.
module seg_scan_mux
  import traffic_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 50_000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                  fast_clk,
  input  logic                  rst,
  input  logic [6:0]            remaining,
  input  state_t                state,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] digit
);

  localparam int SCW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SELW = $clog2(NUM_DIGITS);

  logic [SCW-1:0]        scan_cnt;
  logic [SELW-1:0]       sel;
  logic                  scan_wrap;
  logic [3:0]            ones;
  logic [3:0]            tens;
  logic                  counting;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] digit_next;

  assign scan_wrap = (scan_cnt == SCW'(SCAN_DIV - 1));

  always_comb begin
    ones       = 4'(remaining % 7'd10);
    tens       = 4'(remaining / 7'd10);
    counting   = (state == RED) || (state == GREEN) || (state == YELLOW);
    seg_next   = SEG_DASH;
    digit_next = '0;
    // An out-of-range select drives no digit and shows a dash.
    if (int'(sel) < NUM_DIGITS) begin
      digit_next = NUM_DIGITS'(1) << sel;
      if (int'(sel) == NUM_DIGITS - 1) begin
        case (state)
          RED:     seg_next = SEG_R;
          GREEN:   seg_next = SEG_G;
          YELLOW:  seg_next = SEG_Y;
`ifdef NIGHT_FLASH_EN
          FLASH:   seg_next = SEG_Y;
`endif
          default: seg_next = SEG_DASH;
        endcase
      end else if (sel == SELW'(0)) begin
        if (counting) seg_next = seg_digit(ones);
`ifdef NIGHT_FLASH_EN
        else if (state == FLASH) seg_next = SEG_BLANK;
`endif
      end else if (sel == SELW'(1)) begin
        if (counting) seg_next = (tens == 4'd0) ? SEG_BLANK : seg_digit(tens);
`ifdef NIGHT_FLASH_EN
        else if (state == FLASH) seg_next = SEG_BLANK;
`endif
      end
    end
  end

  always_ff @(posedge fast_clk) begin
    if (rst) begin
      scan_cnt <= '0;
      sel      <= '0;
      seg      <= SEG_DASH;
      digit    <= NUM_DIGITS'(1);
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) sel <= (int'(sel) >= NUM_DIGITS - 1) ? '0 : sel + 1'b1;
      seg   <= seg_next;
      digit <= digit_next;
    end
  end

endmodule

// File: rtl/traffic_light_disp_ctrl.sv
// Timed RED->GREEN->YELLOW light controller with pedestrian shortening and N-digit display.
// Define NIGHT_FLASH_EN to add the night_mode input and the flashing-yellow FLASH state.
module traffic_light_disp_ctrl
  import traffic_disp_pkg::*;
#(
  parameter int TICK_DIV      = 50_000_000,
  parameter int SCAN_DIV      = 50_000,
  parameter int NUM_DIGITS    = 4,
  parameter int RED_SEC       = 10,
  parameter int GREEN_SEC     = 8,
  parameter int YELLOW_SEC    = 3,
  parameter int PED_GREEN_SEC = 2
) (
  input  logic                  fast_clk,
  input  logic                  rst,
  input  logic                  ped_req,
`ifdef NIGHT_FLASH_EN
  input  logic                  night_mode,
`endif
  output logic [2:0]            light,
  output logic [6:0]            remaining,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] digit
);

  localparam int         TCW      = $clog2(TICK_DIV);
  localparam logic [6:0] RED_T    = 7'(RED_SEC);
  localparam logic [6:0] GREEN_T  = 7'(GREEN_SEC);
  localparam logic [6:0] YELLOW_T = 7'(YELLOW_SEC);
  localparam logic [6:0] PED_T    = 7'((PED_GREEN_SEC < GREEN_SEC) ? PED_GREEN_SEC : GREEN_SEC);

  logic [TCW-1:0] tick_cnt;
  logic           tick;
  state_t         state_q, state_d;
  logic [6:0]     rem_q, rem_d;
  logic [2:0]     light_q, light_d;
  logic           ped_q, ped_d;

  assign tick      = (tick_cnt == TCW'(TICK_DIV - 1));
  assign light     = light_q;
  assign remaining = rem_q;

  always_ff @(posedge fast_clk) begin
    if (rst) begin
      tick_cnt <= '0;
      state_q  <= RED;
      rem_q    <= RED_T;
      light_q  <= LIGHT_RED;
      ped_q    <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      state_q  <= state_d;
      rem_q    <= rem_d;
      light_q  <= light_d;
      ped_q    <= ped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    light_d = light_q;
    ped_d   = ped_q;
`ifdef NIGHT_FLASH_EN
    if (tick && night_mode) begin
      state_d = FLASH;
      rem_d   = 7'd0;
      ped_d   = 1'b0;
      light_d = (state_q == FLASH && light_q == LIGHT_YELLOW) ? LIGHT_OFF : LIGHT_YELLOW;
    end else
`endif
    begin
      case (state_q)
        RED: begin
          if (ped_req) ped_d = 1'b1;
          if (tick) begin
            if (rem_q > 7'd1) begin
              rem_d = rem_q - 7'd1;
            end else begin
              state_d = GREEN;
              light_d = LIGHT_GREEN;
              rem_d   = (ped_q || ped_req) ? PED_T : GREEN_T;
              ped_d   = 1'b0;
            end
          end
        end
        GREEN: begin
          // A pedestrian cut swallows a coincident tick rather than decrementing too.
          if (ped_req && rem_q > PED_T) begin
            rem_d = PED_T;
          end else if (tick) begin
            if (rem_q > 7'd1) begin
              rem_d = rem_q - 7'd1;
            end else begin
              state_d = YELLOW;
              light_d = LIGHT_YELLOW;
              rem_d   = YELLOW_T;
            end
          end
        end
        YELLOW: begin
          if (ped_req) ped_d = 1'b1;
          if (tick) begin
            if (rem_q > 7'd1) begin
              rem_d = rem_q - 7'd1;
            end else begin
              state_d = RED;
              light_d = LIGHT_RED;
              rem_d   = RED_T;
            end
          end
        end
`ifdef NIGHT_FLASH_EN
        FLASH: begin
          if (tick) begin
            state_d = RED;
            light_d = LIGHT_RED;
            rem_d   = RED_T;
          end
        end
`endif
        default: begin
          if (tick) begin
            state_d = RED;
            light_d = LIGHT_RED;
            rem_d   = RED_T;
            ped_d   = 1'b0;
          end
        end
      endcase
    end
  end

  seg_scan_mux #(
    .SCAN_DIV  (SCAN_DIV),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_scan (
    .fast_clk (fast_clk),
    .rst      (rst),
    .remaining(rem_q),
    .state    (state_q),
    .seg      (seg),
    .digit    (digit)
  );

endmodule
